vend_dispenser: RTL and testbench
=================================

VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning request queue depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter MOTOR_TIMEOUT, default 16, meaning the maximum number of MOTOR cycles to wait for motor_done.
REQ-003 The block SHALL have parameter EJECT_HIGH, default 2, meaning coin_eject pulse width in cycles (>=1).
REQ-004 The block SHALL have parameter EJECT_GAP, default 2, meaning low cycles after each coin pulse (>=1).
REQ-005 The block SHALL have port clk, input, 1 bit, the clock; all logic SHALL be rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port vend_in, input, 1 bit, a product-release request from the vending FSM, sampled every cycle.
REQ-008 The block SHALL have port change_in, input, 2 bits, the number of 1-rupee coins to return (0..3), sampled every cycle.
REQ-009 The block SHALL have port motor_done, input, 1 bit, the product-drop sensor, level-sampled.
REQ-010 The block SHALL have port motor_en, output, 1 bit, the product motor drive.
REQ-011 The block SHALL have port coin_eject, output, 1 bit, the coin ejector solenoid; one pulse releases one coin.
REQ-012 The block SHALL have ports busy, full, overflow and fault, outputs, 1 bit each, carrying status.
REQ-013 The block SHALL have port vend_cnt, output, 8 bits, the count of completed product drops.

Function
REQ-014 A request SHALL exist in a cycle where vend_in=1 or change_in!=0; it SHALL be pushed as entry {vend_in, change_in} when full=0 and fault=0.
REQ-015 A request arriving while full=1 or fault=1 SHALL be dropped and SHALL set overflow, which remains sticky until rst.
REQ-016 full SHALL be derived from the registered occupancy (occupancy==FIFO_DEPTH); a push in a full cycle SHALL be rejected even if a pop occurs in the same cycle.
REQ-017 A simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, MOTOR, EJ_ON, EJ_GAP and FAULT.
REQ-019 In IDLE with the queue non-empty, the FSM SHALL pop the head at that edge, load coins_left=change, and go to MOTOR if vend=1, else to EJ_ON.
REQ-020 Latency: for a request captured at edge E into an empty queue in IDLE, the first output (motor_en or coin_eject) SHALL be high in the cycle after edge E+1.
REQ-021 MOTOR: motor_en=1 and a wait counter cleared on entry; when motor_done=1 is sampled, vend_cnt SHALL increment (wrapping 255->0) and the FSM SHALL go to EJ_ON if coins_left>0, else to IDLE.
REQ-022 MOTOR: if MOTOR_TIMEOUT cycles elapse with no motor_done, the FSM SHALL go to FAULT with motor_en low, and vend_cnt SHALL remain unchanged.
REQ-023 EJ_ON SHALL hold coin_eject=1 for exactly EJECT_HIGH cycles, then go to EJ_GAP and decrement coins_left.
REQ-024 EJ_GAP SHALL hold coin_eject=0 for exactly EJECT_GAP cycles, then go to EJ_ON if coins_left>0, else to IDLE.
REQ-025 The FSM SHALL never assert motor_en and coin_eject in the same cycle.
REQ-026 FAULT SHALL be terminal until rst: fault=1, motor_en=0, coin_eject=0, pushes refused (REQ-015), and queue contents retained.
REQ-027 busy SHALL equal (state!=IDLE) or (occupancy!=0).
REQ-028 motor_en, coin_eject and all status outputs SHALL be registered.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set state=IDLE, empty the queue, and zero coins_left and the counters.
REQ-030 While rst=1 at an edge, the block SHALL drive motor_en=0, coin_eject=0, busy=0, full=0, overflow=0, fault=0 and vend_cnt=0.
REQ-031 rst SHALL take priority over every other input, including mid-pulse and mid-MOTOR, and requests presented during rst SHALL be discarded.

Verification
REQ-032 vend_in=1, change_in=0 for one cycle; motor_done=1 on the 3rd MOTOR cycle -> motor_en high for 3 cycles, vend_cnt=1, return to IDLE, busy=0.
REQ-033 change_in=2, vend_in=0 for one cycle -> coin_eject pattern 1,1,0,0,1,1,0,0 with no motor_en, then IDLE.
REQ-034 vend_in=1, change_in=1, with motor_done after 1 cycle -> motor_en for 1 cycle, then exactly one 2-cycle coin pulse, vend_cnt=1.
REQ-035 Six back-to-back requests while MOTOR is stalled -> first popped, next 4 queued, full=1, 6th dropped with overflow=1, and the queued entries are dispensed in order.
REQ-036 vend_in=1 and motor_done held 0 -> after 16 MOTOR cycles fault=1 and motor_en=0, a new request is dropped with overflow=1, and rst clears all outputs to 0.
REQ-037 rst asserted during the 2nd EJ_ON cycle of a 3-coin request -> coin_eject=0 on the next cycle, the queue is empty, and no further pulses occur.

Source files
------------

// File: rtl/vend_dispenser.sv
// rtl/vend_dispenser.sv - product motor and coin ejector sequencer fed by a small request queue
module vend_dispenser #(
    parameter int FIFO_DEPTH    = 4,
    parameter int MOTOR_TIMEOUT = 16,
    parameter int EJECT_HIGH    = 2,
    parameter int EJECT_GAP     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_in,
    input  logic [1:0] change_in,
    input  logic       motor_done,
    output logic       motor_en,
    output logic       coin_eject,
    output logic       busy,
    output logic       full,
    output logic       overflow,
    output logic       fault,
    output logic [7:0] vend_cnt
);

    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW   = $clog2(FIFO_DEPTH + 1);
    localparam int TM1  = (MOTOR_TIMEOUT > EJECT_HIGH) ? MOTOR_TIMEOUT : EJECT_HIGH;
    localparam int TMAX = (TM1 > EJECT_GAP) ? TM1 : EJECT_GAP;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_EJ_ON,
        S_EJ_GAP,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [1:0]    coins_q, coins_d;
    logic [7:0]    vend_cnt_q, vend_cnt_d;
    logic [2:0]    fifo_q [FIFO_DEPTH];
    logic [2:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          motor_en_q, motor_en_d;
    logic          coin_eject_q, coin_eject_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          fault_q, fault_d;

    logic          req;
    logic          push;
    logic          pop;
    logic [2:0]    head;

    // Queue side: admission decisions use only registered full/fault.
    always_comb begin
        req      = vend_in | (change_in != 2'd0);
        push     = req & ~full_q & ~fault_q;
        head     = fifo_q[rd_ptr_q];
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {vend_in, change_in};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        coins_d    = coins_q;
        vend_cnt_d = vend_cnt_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (occ_q != '0) begin
                    pop     = 1'b1;
                    coins_d = head[1:0];
                    phase_d = '0;
                    state_d = head[2] ? S_MOTOR : S_EJ_ON;
                end
            end
            S_MOTOR: begin
                if (motor_done) begin
                    vend_cnt_d = vend_cnt_q + 8'd1;
                    phase_d    = '0;
                    state_d    = (coins_q != 2'd0) ? S_EJ_ON : S_IDLE;
                end else if (phase_q == CW'(MOTOR_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_EJ_ON: begin
                if (phase_q == CW'(EJECT_HIGH - 1)) begin
                    phase_d = '0;
                    coins_d = coins_q - 2'd1;
                    state_d = S_EJ_GAP;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_EJ_GAP: begin
                if (phase_q == CW'(EJECT_GAP - 1)) begin
                    phase_d = '0;
                    state_d = (coins_q != 2'd0) ? S_EJ_ON : S_IDLE;
                end else begin
                    phase_d = phase_q + CW'(1);
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so the first drive appears right after the pop edge.
    always_comb begin
        motor_en_d   = (state_d == S_MOTOR);
        coin_eject_d = (state_d == S_EJ_ON);
        busy_d       = (state_d != S_IDLE) || (occ_d != '0);
        full_d       = (occ_d == OW'(FIFO_DEPTH));
        fault_d      = (state_d == S_FAULT);
        overflow_d   = overflow_q | (req & (full_q | fault_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            coins_q      <= '0;
            vend_cnt_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            motor_en_q   <= 1'b0;
            coin_eject_q <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            coins_q      <= coins_d;
            vend_cnt_q   <= vend_cnt_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            motor_en_q   <= motor_en_d;
            coin_eject_q <= coin_eject_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            fault_q      <= fault_d;
        end
    end

    assign motor_en   = motor_en_q;
    assign coin_eject = coin_eject_q;
    assign busy       = busy_q;
    assign full       = full_q;
    assign overflow   = overflow_q;
    assign fault      = fault_q;
    assign vend_cnt   = vend_cnt_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// tb/tb_vend_dispenser.sv - table-driven and sequence checks of vend_dispenser output traces
module tb_vend_dispenser;

    localparam int EH = 2;
    localparam int EG = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       vend_in;
    logic [1:0] change_in;
    logic       motor_done;
    logic       motor_en;
    logic       coin_eject;
    logic       busy;
    logic       full;
    logic       overflow;
    logic       fault;
    logic [7:0] vend_cnt;

    vend_dispenser #(
        .FIFO_DEPTH(4),
        .MOTOR_TIMEOUT(16),
        .EJECT_HIGH(EH),
        .EJECT_GAP(EG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vend_in(vend_in),
        .change_in(change_in),
        .motor_done(motor_done),
        .motor_en(motor_en),
        .coin_eject(coin_eject),
        .busy(busy),
        .full(full),
        .overflow(overflow),
        .fault(fault),
        .vend_cnt(vend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic m;
        logic c;
        logic b;
    } exp_t;

    typedef struct {
        logic       vend;
        logic [1:0] change;
        int         done_cycle;
        int         exp_motor;
        int         exp_pulses;
        int         exp_drop;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[7];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt;
    int         done_from;
    int         samp_idx;
    localparam int NEVER = 1 << 30;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic m, input logic c, input logic b);
        exp_t e;
        e.m = m;
        e.c = c;
        e.b = b;
        exp_q.push_back(e);
    endtask

    // Motor cycles, then per coin EH high and EG low cycles, then one idle cycle.
    task automatic push_trace(input int motor_cycles, input int pulses, input logic last_busy);
        for (int i = 0; i < motor_cycles; i++) push_exp(1'b1, 1'b0, 1'b1);
        for (int p = 0; p < pulses; p++) begin
            for (int h = 0; h < EH; h++) push_exp(1'b0, 1'b1, 1'b1);
            for (int g = 0; g < EG; g++) push_exp(1'b0, 1'b0, 1'b1);
        end
        push_exp(1'b0, 1'b0, last_busy);
    endtask

    task automatic sample_one();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("trace_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("motor_en", motor_en, e.m);
            chk("coin_eject", coin_eject, e.c);
            chk("busy", busy, e.b);
            chk("exclusive_drive", motor_en & coin_eject, 0);
        end
        motor_done = (samp_idx >= done_from);
        samp_idx++;
    endtask

    task automatic drain();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            sample_one();
        end
        chk("vend_cnt", vend_cnt, exp_cnt);
        motor_done = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        vend_in    = v.vend;
        change_in  = v.change;
        motor_done = 1'b0;
        samp_idx   = 0;
        done_from  = (v.done_cycle > 0) ? v.done_cycle - 1 : NEVER;
        push_trace(v.exp_motor, v.exp_pulses, 1'b0);
        exp_cnt    = exp_cnt + 8'(v.exp_drop);
        @(negedge clk);
        vend_in   = 1'b0;
        change_in = 2'd0;
        drain();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_motor_en"}, motor_en, 0);
        chk({tag, "_coin_eject"}, coin_eject, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_vend_cnt"}, vend_cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0] reqs [6];

        vecs[0] = '{1'b1, 2'd0, 3, 3, 0, 1};
        vecs[1] = '{1'b0, 2'd2, 0, 0, 2, 0};
        vecs[2] = '{1'b1, 2'd1, 1, 1, 1, 1};
        vecs[3] = '{1'b1, 2'd3, 2, 2, 3, 1};
        vecs[4] = '{1'b0, 2'd3, 0, 0, 3, 0};
        vecs[5] = '{1'b1, 2'd0, 16, 16, 0, 1};
        vecs[6] = '{1'b0, 2'd1, 0, 0, 1, 0};

        rst        = 1'b1;
        vend_in    = 1'b0;
        change_in  = 2'd0;
        motor_done = 1'b0;
        exp_cnt    = 8'd0;
        samp_idx   = 0;
        done_from  = NEVER;

        // Reset state, with a request presented during reset that must be discarded.
        repeat (2) @(negedge clk);
        vend_in   = 1'b1;
        change_in = 2'd3;
        @(negedge clk);
        chk_all_zero("reset");
        rst       = 1'b0;
        vend_in   = 1'b0;
        change_in = 2'd0;
        repeat (4) push_exp(1'b0, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            sample_one();
        end

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // vend_cnt wraps 255 -> 0.
        for (int i = 0; i < 300 && exp_cnt != 8'd0; i++) run_vec('{1'b1, 2'd0, 1, 1, 0, 1});
        chk("vend_cnt_wrap", vend_cnt, 0);

        // Six back-to-back requests while the first one stalls in MOTOR.
        reqs[0] = 3'b100;
        reqs[1] = 3'b001;
        reqs[2] = 3'b010;
        reqs[3] = 3'b011;
        reqs[4] = 3'b101;
        reqs[5] = 3'b100;
        samp_idx  = 0;
        done_from = 7;
        push_trace(8, 0, 1'b1);
        push_trace(0, 1, 1'b1);
        push_trace(0, 2, 1'b1);
        push_trace(0, 3, 1'b1);
        push_trace(1, 1, 1'b0);
        exp_cnt = exp_cnt + 8'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) sample_one();
            if (i == 4) chk("full_at_3", full, 0);
            if (i == 5) begin
                chk("full_at_4", full, 1);
                chk("overflow_before_drop", overflow, 0);
            end
            {vend_in, change_in} = reqs[i];
        end
        @(negedge clk);
        sample_one();
        chk("overflow_after_drop", overflow, 1);
        chk("full_after_drop", full, 1);
        vend_in   = 1'b0;
        change_in = 2'd0;
        drain();
        chk("overflow_sticky", overflow, 1);
        chk("full_drained", full, 0);

        // Motor timeout into FAULT, then reset recovery.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = 8'd0;
        chk("overflow_cleared", overflow, 0);
        @(negedge clk);
        vend_in   = 1'b1;
        samp_idx  = 0;
        done_from = NEVER;
        push_trace(16, 0, 1'b1);
        @(negedge clk);
        vend_in = 1'b0;
        drain();
        chk("fault_set", fault, 1);
        chk("fault_motor_off", motor_en, 0);
        chk("fault_no_overflow_yet", overflow, 0);
        vend_in = 1'b1;
        @(negedge clk);
        vend_in = 1'b0;
        chk("fault_overflow", overflow, 1);
        chk("fault_held", fault, 1);
        chk("fault_busy", busy, 1);
        chk("fault_coin_off", coin_eject, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("fault_rst");
        rst = 1'b0;

        // Reset during the second EJ_ON cycle of a three-coin request.
        @(negedge clk);
        change_in = 2'd3;
        samp_idx  = 0;
        done_from = NEVER;
        push_exp(1'b0, 1'b1, 1'b1);
        push_exp(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        change_in = 2'd0;
        @(negedge clk);
        sample_one();
        @(negedge clk);
        sample_one();
        rst = 1'b1;
        repeat (6) push_exp(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        sample_one();
        rst = 1'b0;
        drain();
        chk("midpulse_rst_full", full, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
